uart_echo_fifo: RTL

Parametrised echo engine between the receive and transmit byte interfaces of the team's uart core. Received bytes pass through a configurable-depth FIFO, an optional per-byte transform (upper/lower case) and an optional line-buffered mode, then go back out on the transmit side. Framing errors, overflows and transmit stalls are tracked. Top level of the next-generation echo test design; the uart instance sits alongside it in the wrapper.

---
 rtl/uart_echo_pkg.sv | 31 +++
 rtl/uart_echo_fifo_sync_fifo.sv | 67 ++++++
 rtl/uart_echo_fifo.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/uart_echo_pkg.sv
// Shared definitions for the uart echo path: mode encodings, the CR
// character that triggers a line flush, the transmit FSM state type and
// the per-byte case transform.
package uart_echo_pkg;

    localparam logic [1:0] MODE_PASS  = 2'd0;
    localparam logic [1:0] MODE_UPPER = 2'd1;
    localparam logic [1:0] MODE_LOWER = 2'd2;
    localparam logic [1:0] MODE_LINE  = 2'd3;

    localparam logic [7:0] CHAR_CR = 8'h0D;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_BUSY = 2'd1,
        ST_WAIT_DONE = 2'd2
    } echo_state_t;

    // Case transform applied as a byte enters the FIFO; non-letters pass through.
    function automatic logic [7:0] xform_byte(input logic [1:0] mode, input logic [7:0] b);
        logic [7:0] r;
        r = b;
        if (mode == MODE_UPPER && b >= 8'h61 && b <= 8'h7A) begin
            r = b - 8'h20;
        end else if (mode == MODE_LOWER && b >= 8'h41 && b <= 8'h5A) begin
            r = b + 8'h20;
        end
        return r;
    endfunction

endpackage

// File: rtl/uart_echo_fifo_sync_fifo.sv
// Generic synchronous FIFO, power-of-two depth.
// Ports: clk, rst_n (sync, active low), push/wdata, pop, head_c (combinational
// head-of-queue data), full, empty, level (registered occupancy).
// A push while full or a pop while empty is ignored.
module sync_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head_c,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned LW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [LW-1:0]    level_next;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head_c  = mem[rd_ptr];

    // Occupancy update; simultaneous push and pop leaves it unchanged.
    always_comb begin
        level_next = level;
        case ({do_push, do_pop})
            2'b10:   level_next = level + LW'(1);
            2'b01:   level_next = level - LW'(1);
            default: level_next = level;
        endcase
    end

    // Storage array, no reset needed.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            level <= level_next;
            full  <= (level_next == LW'(DEPTH));
            empty <= (level_next == '0);
        end
    end

endmodule

// File: rtl/uart_echo_fifo.sv
// Echo engine between the uart receive and transmit byte interfaces.
// Received bytes are case-transformed, queued and replayed to the transmitter
// one at a time with a tx_start/tx_busy handshake.
// Ports: clk, rst_n (sync active low), mode, rx_valid/rx_data/rx_error,
// tx_start/tx_data/tx_busy, fifo_level, overflow, timeout, err_count,
// rx_count, tx_count.
// Build option: define ECHO_STATS_EN to get live rx_count/tx_count counters;
// otherwise both ports read 0.
module uart_echo_fifo
    import uart_echo_pkg::*;
#(
    parameter int unsigned DEPTH        = 16,
    parameter int unsigned CNT_WIDTH    = 16,
    parameter int unsigned BUSY_TIMEOUT = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [1:0]              mode,
    input  logic                    rx_valid,
    input  logic [7:0]              rx_data,
    input  logic                    rx_error,
    output logic                    tx_start,
    output logic [7:0]              tx_data,
    input  logic                    tx_busy,
    output logic [$clog2(DEPTH):0]  fifo_level,
    output logic                    overflow,
    output logic                    timeout,
    output logic [CNT_WIDTH-1:0]    err_count,
    output logic [CNT_WIDTH-1:0]    rx_count,
    output logic [CNT_WIDTH-1:0]    tx_count
);
    localparam int unsigned TW = $clog2(BUSY_TIMEOUT + 1);

    echo_state_t   state, state_next;
    logic [7:0]    wdata;
    logic [7:0]    head_c;
    logic          full, empty;
    logic          push_c, pop_c;
    logic          drain_en;
    logic          flush, flush_next;
    logic          tx_start_next;
    logic [7:0]    tx_data_next;
    logic          timeout_next;
    logic [TW-1:0] wait_cnt, wait_cnt_next;

    assign wdata  = xform_byte(mode, rx_data);
    // Full is judged on the occupancy before this cycle, so a pop cannot make room.
    assign push_c = rx_valid && !rx_error && !full;

    sync_fifo #(.DEPTH(DEPTH), .WIDTH(8)) u_fifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .push   (push_c),
        .wdata  (wdata),
        .pop    (pop_c),
        .head_c (head_c),
        .full   (full),
        .empty  (empty),
        .level  (fifo_level)
    );

    // Line mode holds bytes until a CR arrives or the FIFO fills, then drains to empty.
    always_comb begin
        flush_next = flush;
        if (mode != MODE_LINE) begin
            flush_next = 1'b0;
        end else if ((push_c && wdata == CHAR_CR) || full) begin
            flush_next = 1'b1;
        end else if (empty) begin
            flush_next = 1'b0;
        end
    end

    assign drain_en = !empty && ((mode != MODE_LINE) || flush);

    // Transmit handshake FSM: next state and registered-output next values.
    always_comb begin
        state_next    = state;
        tx_start_next = 1'b0;
        tx_data_next  = tx_data;
        timeout_next  = timeout;
        wait_cnt_next = wait_cnt;
        pop_c         = 1'b0;
        case (state)
            ST_IDLE: begin
                if (drain_en && !tx_busy) begin
                    pop_c         = 1'b1;
                    tx_start_next = 1'b1;
                    tx_data_next  = head_c;
                    wait_cnt_next = '0;
                    state_next    = ST_WAIT_BUSY;
                end
            end
            ST_WAIT_BUSY: begin
                if (tx_busy) begin
                    state_next = ST_WAIT_DONE;
                end else if (wait_cnt == TW'(BUSY_TIMEOUT - 1)) begin
                    // Transmitter never took the byte; give up on it.
                    timeout_next = 1'b1;
                    state_next   = ST_IDLE;
                end else begin
                    wait_cnt_next = wait_cnt + TW'(1);
                end
            end
            ST_WAIT_DONE: begin
                if (!tx_busy) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // State, handshake outputs and error tracking.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            tx_start  <= 1'b0;
            tx_data   <= '0;
            timeout   <= 1'b0;
            wait_cnt  <= '0;
            flush     <= 1'b0;
            overflow  <= 1'b0;
            err_count <= '0;
        end else begin
            state    <= state_next;
            tx_start <= tx_start_next;
            tx_data  <= tx_data_next;
            timeout  <= timeout_next;
            wait_cnt <= wait_cnt_next;
            flush    <= flush_next;
            if (rx_valid && !rx_error && full) begin
                overflow <= 1'b1;
            end
            if (rx_valid && rx_error && (err_count != '1)) begin
                err_count <= err_count + CNT_WIDTH'(1);
            end
        end
    end

`ifdef ECHO_STATS_EN
    logic [CNT_WIDTH-1:0] rx_cnt_q, tx_cnt_q;

    // Saturating accepted/completed byte counters.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_cnt_q <= '0;
            tx_cnt_q <= '0;
        end else begin
            if (push_c && (rx_cnt_q != '1)) begin
                rx_cnt_q <= rx_cnt_q + CNT_WIDTH'(1);
            end
            if (state == ST_WAIT_DONE && !tx_busy && (tx_cnt_q != '1)) begin
                tx_cnt_q <= tx_cnt_q + CNT_WIDTH'(1);
            end
        end
    end

    assign rx_count = rx_cnt_q;
    assign tx_count = tx_cnt_q;
`else
    assign rx_count = '0;
    assign tx_count = '0;
`endif

endmodule
